// File: rtl/syzygy_adc_frame_align.sv
// Frame-clock bit-alignment trainer: slips the ISERDES until the FR lane word matches
// FRAME_PATTERN, then monitors it and retrains on lock loss, realign or a run of misses.
module syzygy_adc_frame_align #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] FRAME_PATTERN = 8'hF0,
  parameter int               LOCK_WAIT     = 64,
  parameter int               SETTLE_CYCLES = 4,
  parameter int               MATCH_COUNT   = 16,
  parameter int               MISS_LIMIT    = 4,
  parameter int               MAX_SLIPS     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             locked,
  input  logic             realign,
  input  logic [WIDTH-1:0] frame_data,
  output logic             bitslip,
  output logic             aligned,
  output logic             fail,
  output logic [3:0]       slip_count,
  output logic [2:0]       state
);

  localparam int WW = $clog2(LOCK_WAIT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int XW = $clog2(MISS_LIMIT + 1);

  localparam logic [WW-1:0] WAIT_LAST   = WW'(LOCK_WAIT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_COUNT - 1);
  localparam logic [XW-1:0] MISS_LAST   = XW'(MISS_LIMIT - 1);
  localparam logic [3:0]    SLIP_MAX    = 4'(MAX_SLIPS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CHECK   = 3'd2,
    ST_SLIP    = 3'd3,
    ST_ALIGNED = 3'd4,
    ST_FAIL    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    lock_sync_q;
  logic [WW-1:0] wait_q, wait_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [MW-1:0] match_q, match_d;
  logic [XW-1:0] miss_q, miss_d;
  logic [3:0]    slip_q, slip_d;
  logic          fail_q, fail_d;
  logic          aligned_q, bitslip_q;
  logic          locked_s, word_ok;

  assign locked_s = lock_sync_q[1];
  assign word_ok  = (frame_data == FRAME_PATTERN);

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    settle_d = settle_q;
    match_d  = match_q;
    miss_d   = miss_q;
    slip_d   = slip_q;
    fail_d   = fail_q;
    if (!locked_s) begin
      // Lock loss restarts training but leaves a previous failure visible.
      state_d  = ST_IDLE;
      wait_d   = '0;
      settle_d = '0;
      match_d  = '0;
      miss_d   = '0;
      slip_d   = '0;
    end else if (realign) begin
      state_d  = ST_IDLE;
      wait_d   = '0;
      settle_d = '0;
      match_d  = '0;
      miss_d   = '0;
      slip_d   = '0;
      fail_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wait_q == WAIT_LAST) begin
            state_d  = ST_SETTLE;
            wait_d   = '0;
            settle_d = '0;
            slip_d   = '0;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_d  = ST_CHECK;
            settle_d = '0;
            match_d  = '0;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        ST_CHECK: begin
          if (word_ok) begin
            if (match_q == MATCH_LAST) begin
              state_d = ST_ALIGNED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
            state_d = (slip_q == SLIP_MAX) ? ST_FAIL : ST_SLIP;
          end
        end
        ST_SLIP: begin
          if (slip_q != 4'hF) slip_d = slip_q + 1'b1;
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
        ST_ALIGNED: begin
          if (word_ok) begin
            miss_d = '0;
          end else if (miss_q == MISS_LAST) begin
            state_d  = ST_SETTLE;
            settle_d = '0;
            miss_d   = '0;
            slip_d   = '0;
          end else begin
            miss_d = miss_q + 1'b1;
          end
        end
        ST_FAIL: ;
        default: state_d = ST_IDLE;
      endcase
    end
    // A successful retrain after a lock-loss clears a stale failure so aligned/fail stay exclusive.
    if (state_d == ST_ALIGNED) fail_d = 1'b0;
    else if (state_d == ST_FAIL) fail_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_sync_q <= '0;
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      settle_q    <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      slip_q      <= '0;
      fail_q      <= 1'b0;
      aligned_q   <= 1'b0;
      bitslip_q   <= 1'b0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], locked};
      state_q     <= state_d;
      wait_q      <= wait_d;
      settle_q    <= settle_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      slip_q      <= slip_d;
      fail_q      <= fail_d;
      aligned_q   <= (state_d == ST_ALIGNED);
      bitslip_q   <= (state_d == ST_SLIP);
    end
  end

  assign bitslip    = bitslip_q;
  assign aligned    = aligned_q;
  assign fail       = fail_q;
  assign slip_count = slip_q;
  assign state      = state_q;

endmodule
